// File: rtl/mem_access_arbiter.sv
// -----------------------------------------------------------------------------
// mem_access_arbiter
//   Shares one single-port main memory between the instruction-fetch (IF) and
//   data load/store (DT) requesters. Each requester holds its req until it sees
//   its one-cycle done pulse. Simultaneous requests are resolved round-robin,
//   and every memory-side output comes straight from a register.
//
//   FSM: IDLE -> ACCESS -> DONE -> IDLE
//     IDLE   : requests are sampled; the winner's address/data/we are latched.
//     ACCESS : a read lasts MEM_LAT cycles, a write lasts 1 cycle (mem_wr=1).
//     DONE   : the owner's done is high for one cycle; requests are ignored.
//
// Parameters
//   ADDR_W   address width
//   DATA_W   data width
//   MEM_LAT  read latency (cycles from mem_addr valid to mem_rdata valid), >= 1
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-low reset; all outputs forced to 0
//   if_req     fetch read request (held until if_done)
//   if_addr    fetch address
//   if_rdata   fetched word, valid with if_done and held afterwards
//   if_done    one-cycle fetch-complete pulse
//   dt_req     data request (held until dt_done)
//   dt_we      1 = write, 0 = read
//   dt_addr    data address
//   dt_wdata   store data
//   dt_rdata   loaded word, valid with dt_done and held afterwards
//   dt_done    one-cycle data-access-complete pulse
//   mem_addr   memory address (registered, doubles as the address latch)
//   mem_wdata  memory write data (registered, doubles as the data latch)
//   mem_wr     memory write strobe, high only in the single write cycle
//   mem_rdata  memory read data
//   busy       0 only in IDLE
//   owner      current or last grant: 0 = IF, 1 = DT
// -----------------------------------------------------------------------------
module mem_access_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              dt_req,
  input  logic              dt_we,
  input  logic [ADDR_W-1:0] dt_addr,
  input  logic [DATA_W-1:0] dt_wdata,
  output logic [DATA_W-1:0] dt_rdata,
  output logic              dt_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  // Counter only needs to reach MEM_LAT-1; keep at least one bit so the
  // MEM_LAT=1 case still elaborates cleanly.
  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             last_dt;  // requester served most recently (1 = DT)
  logic             we_lat;   // latched write flag of the current access

  // Round-robin pick: a lone requester always wins; on a tie the one that was
  // not served last wins. Returns 1 when DT gets the grant.
  function automatic logic pick_dt(input logic req_if, input logic req_dt,
                                   input logic last_was_dt);
    return req_dt & (~req_if | ~last_was_dt);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      last_dt   <= 1'b1;  // makes the first tie go to IF
      we_lat    <= 1'b0;
      owner     <= 1'b0;
      busy      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wr    <= 1'b0;
      if_rdata  <= '0;
      dt_rdata  <= '0;
      if_done   <= 1'b0;
      dt_done   <= 1'b0;
    end else begin
      case (state)
        // ---- IDLE: arbitrate and latch the winner's request ----
        IDLE: begin
          if (if_req || dt_req) begin
            if (pick_dt(if_req, dt_req, last_dt)) begin
              owner     <= 1'b1;
              last_dt   <= 1'b1;
              mem_addr  <= dt_addr;
              mem_wdata <= dt_wdata;
              we_lat    <= dt_we;
              mem_wr    <= dt_we;   // strobe lines up with the single write cycle
            end else begin
              // IF never writes; mem_wdata keeps its previous value.
              owner     <= 1'b0;
              last_dt   <= 1'b0;
              mem_addr  <= if_addr;
              we_lat    <= 1'b0;
              mem_wr    <= 1'b0;
            end
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ACCESS;
          end
        end

        // ---- ACCESS: drive the memory for the write cycle or MEM_LAT reads ----
        ACCESS: begin
          if (we_lat) begin
            mem_wr  <= 1'b0;
            dt_done <= 1'b1;
            state   <= DONE;
          end else if (cnt == CNT_LAST) begin
            if (owner) begin
              dt_rdata <= mem_rdata;
              dt_done  <= 1'b1;
            end else begin
              if_rdata <= mem_rdata;
              if_done  <= 1'b1;
            end
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // ---- DONE: one cycle of done, requests ignored ----
        DONE: begin
          if_done <= 1'b0;
          dt_done <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end

        default: begin
          mem_wr  <= 1'b0;
          if_done <= 1'b0;
          dt_done <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
